// File: rtl/main_mem_ctrl_pkg.sv
// Shared types and helpers for the main-memory responder.
// Request bundle layout, size encodings and store lane helpers.
package main_mem_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = 32;
  localparam int ICACHE_DATA_BLOCK_SIZE = 64;

  localparam logic [2:0] MEM_SIZE_W = 3'b100;
  localparam logic [2:0] MEM_SIZE_H = 3'b010;
  localparam logic [2:0] MEM_SIZE_B = 3'b001;

  typedef struct packed {
    logic                  we;
    logic                  lsu_aL_ifu_aH;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic [WORD_WIDTH-1:0] data;
  } main_mem_req_t;

  localparam int MAIN_MEM_REQ_WIDTH = $bits(main_mem_req_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } mem_state_e;

  // Zero mask for misaligned or non-one-hot sizes.
  function automatic logic [7:0] store_mask(
    input logic [2:0] size,
    input logic [2:0] off
  );
    logic [7:0] m;
    m = '0;
    case (size)
      MEM_SIZE_B: m = 8'h01 << off;
      MEM_SIZE_H: if (!off[0]) m = 8'h03 << off;
      MEM_SIZE_W: if (off[1:0] == 2'b00) m = 8'h0f << off;
      default:    m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [ICACHE_DATA_BLOCK_SIZE-1:0] store_data(
    input logic [WORD_WIDTH-1:0] d,
    input logic [2:0]            off
  );
    logic [ICACHE_DATA_BLOCK_SIZE-1:0] w;
    w = {{(ICACHE_DATA_BLOCK_SIZE-WORD_WIDTH){1'b0}}, d};
    return w << {off, 3'b000};
  endfunction

endpackage

// File: rtl/main_mem_ctrl_fifo.sv
// In-order request queue with registered occupancy.
// Push while full is taken only when a pop happens in the same cycle.
module main_mem_ctrl_fifo #(
  parameter int ENTRY_WIDTH = 8,
  parameter int N_ENTRIES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] din,
  input  logic                   pop,
  output logic [ENTRY_WIDTH-1:0] dout,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [ENTRY_WIDTH-1:0] mem [N_ENTRIES];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(N_ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(N_ENTRIES));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Behavioural main-memory responder: queued loads/stores,
// fixed service latency, 64-bit block responses.
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY      = 10,
  parameter int MEM_DEPTH_BLOCKS = 1024,
  parameter int REQ_FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_aL,
  input  logic                              send_en_main_mem,
  output logic                              send_main_mem_ready,
  input  logic                              send_main_mem_we,
  input  logic                              send_main_mem_lsu_aL_ifu_aH,
  input  logic [ADDR_WIDTH-1:0]             send_main_mem_addr,
  input  logic [2:0]                        send_size_main_mem,
  input  logic [WORD_WIDTH-1:0]             send_main_mem_data,
  output logic                              recv_main_mem_valid,
  output logic                              recv_main_mem_lsu_aL_ifu_aH,
  output logic [ADDR_WIDTH-1:0]             recv_main_mem_addr,
  output logic [ICACHE_DATA_BLOCK_SIZE-1:0] recv_main_mem_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  main_mem_req_t req_in;
  main_mem_req_t head;
  main_mem_req_t svc;
  mem_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic          rdy_en;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_push;
  logic          done;
  logic [IDX_W-1:0] svc_idx;
  logic [7:0]    wmask;
  logic [ICACHE_DATA_BLOCK_SIZE-1:0] wdata;

  logic [ICACHE_DATA_BLOCK_SIZE-1:0] mem [MEM_DEPTH_BLOCKS];

  assign req_in = {send_main_mem_we, send_main_mem_lsu_aL_ifu_aH,
                   send_main_mem_addr, send_size_main_mem,
                   send_main_mem_data};

  // Ready comes only from registered state: no pop-to-ready path.
  assign send_main_mem_ready = rdy_en & ~fifo_full;
  assign fifo_push = send_en_main_mem & send_main_mem_ready;
  assign fifo_pop  = ~fifo_empty &
                     ((state == ST_IDLE) | (state == ST_RESP));

  assign done    = (state == ST_BUSY) && (cnt == '0);
  assign svc_idx = svc.addr[3 +: IDX_W];
  assign wmask   = store_mask(svc.size, svc.addr[2:0]);
  assign wdata   = store_data(svc.data, svc.addr[2:0]);

  main_mem_ctrl_fifo #(
    .ENTRY_WIDTH (MAIN_MEM_REQ_WIDTH),
    .N_ENTRIES   (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_aL(rst_aL),
    .flush (1'b0),
    .push  (fifo_push),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state                       <= ST_IDLE;
      cnt                         <= '0;
      svc                         <= '0;
      rdy_en                      <= 1'b0;
      recv_main_mem_valid         <= 1'b0;
      recv_main_mem_lsu_aL_ifu_aH <= 1'b0;
      recv_main_mem_addr          <= '0;
      recv_main_mem_data          <= '0;
    end else begin
      rdy_en              <= 1'b1;
      recv_main_mem_valid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_RESP: begin
          if (!fifo_empty) begin
            svc   <= head;
            cnt   <= CNT_W'(MEM_LATENCY - 2);
            state <= ST_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            if (!svc.we) begin
              recv_main_mem_valid         <= 1'b1;
              recv_main_mem_lsu_aL_ifu_aH <= svc.lsu_aL_ifu_aH;
              recv_main_mem_addr <= {svc.addr[ADDR_WIDTH-1:3], 3'b000};
              recv_main_mem_data <= mem[svc_idx];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; contents survive rst_aL.
  always_ff @(posedge clk) begin
    if (done && svc.we) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) mem[svc_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: timing/ordering model plus
// directed scenarios with literal expectations.
module tb_main_mem_ctrl;
  import main_mem_ctrl_pkg::*;

  localparam int L     = 10;
  localparam int DEPTH = 1024;
  localparam int QD    = 4;

  logic        clk = 1'b0;
  logic        rst_aL = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic        tag = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  size = '0;
  logic [31:0] data = '0;
  logic        ready;
  logic        rv;
  logic        rtag;
  logic [31:0] raddr;
  logic [63:0] rdata;

  main_mem_ctrl #(
    .MEM_LATENCY     (L),
    .MEM_DEPTH_BLOCKS(DEPTH),
    .REQ_FIFO_DEPTH  (QD)
  ) dut (
    .clk                        (clk),
    .rst_aL                     (rst_aL),
    .send_en_main_mem           (en),
    .send_main_mem_ready        (ready),
    .send_main_mem_we           (we),
    .send_main_mem_lsu_aL_ifu_aH(tag),
    .send_main_mem_addr         (addr),
    .send_size_main_mem         (size),
    .send_main_mem_data         (data),
    .recv_main_mem_valid        (rv),
    .recv_main_mem_lsu_aL_ifu_aH(rtag),
    .recv_main_mem_addr         (raddr),
    .recv_main_mem_data         (rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit alive = 1'b0;
  always @(posedge clk) begin
    cyc++;
    alive = rst_aL;
  end

  typedef struct {
    int          acc;
    int          comp;
    bit          we;
    bit          tag;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          last_comp = 0;
  logic [63:0] mmem [DEPTH];
  logic        last_tag = 1'b0;
  logic [31:0] last_addr = '0;
  logic [63:0] last_data = '0;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h at cycle %0d",
                  nm, got, exp, cyc);
  endtask

  task automatic model_store(exp_t e);
    int n;
    int off;
    int blk;
    off = int'(e.addr % 8);
    blk = int'((e.addr / 8) % DEPTH);
    n = 0;
    if (e.size == 3'b001) n = 1;
    else if (e.size == 3'b010 && e.addr % 2 == 0) n = 2;
    else if (e.size == 3'b100 && e.addr % 4 == 0) n = 4;
    for (int i = 0; i < n; i++)
      mmem[blk][(off+i)*8 +: 8] = e.data[i*8 +: 8];
  endtask

  task automatic compare_cycle();
    int inq;
    bit exp_rdy;
    inq = 0;
    foreach (q[i]) if (q[i].comp - L + 1 > cyc) inq++;
    exp_rdy = alive && rst_aL && (inq < QD);
    chk("ready", ready, exp_rdy);
    if (q.size() > 0 && q[0].comp == cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.we) begin
        model_store(e);
        chk("valid_store", rv, 0);
      end else begin
        last_tag  = e.tag;
        last_addr = {e.addr[31:3], 3'b000};
        last_data = mmem[int'((e.addr / 8) % DEPTH)];
        chk("valid_load", rv, 1);
      end
    end else begin
      chk("valid_idle", rv, 0);
    end
    chk("tag", rtag, last_tag);
    chk("addr", raddr, last_addr);
    chk("data", rdata, last_data);
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic req(input bit w, input bit t, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] d,
                     output int acc);
    int tries;
    exp_t e;
    tries = 0;
    en = 1'b1; we = w; tag = t; addr = a; size = s; data = d;
    while (!ready && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL req_timeout: ready stuck at 0 at cycle %0d", cyc);
      acc = -1;
      en = 1'b0;
      return;
    end
    acc = cyc + 1;
    e.acc = acc; e.we = w; e.tag = t;
    e.addr = a; e.size = s; e.data = d;
    e.comp = ((acc > last_comp) ? acc : last_comp) + L;
    last_comp = e.comp;
    q.push_back(e);
    @(negedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst_aL = 1'b0;
    q.delete();
    last_comp = 0;
    last_tag  = 1'b0;
    last_addr = '0;
    last_data = '0;
    tick(n);
    rst_aL = 1'b1;
  endtask

  logic [31:0] t3_a [5] = '{32'h0, 32'h1000, 32'h2000, 32'h4, 32'h1007};
  logic [31:0] t3_ra[5] = '{32'h0, 32'h1000, 32'h2000, 32'h0, 32'h1000};
  logic [63:0] t3_d [5] = '{64'hCAFEF00D_DEADBEEF, 64'h11223344_AB667788,
                            64'hCAFEF00D_DEADBEEF, 64'hCAFEF00D_DEADBEEF,
                            64'h11223344_AB667788};

  initial begin
    int a;
    int b;
    int acc [5];
    tick(3);
    rst_aL = 1'b1;
    tick(1);
    chk("ready_after_reset", ready, 1);

    // Preload block 0 (one store IFU-tagged) and block 0x200.
    req(1'b1, 1'b0, 32'h0,    MEM_SIZE_W, 32'hDEADBEEF, a);
    req(1'b1, 1'b1, 32'h4,    MEM_SIZE_W, 32'hCAFEF00D, a);
    req(1'b1, 1'b0, 32'h1000, MEM_SIZE_W, 32'h55667788, a);
    req(1'b1, 1'b0, 32'h1004, MEM_SIZE_W, 32'h11223344, a);
    wait_cyc(last_comp + 2);

    req(1'b0, 1'b1, 32'h1004, 3'b000, 32'h0, a);
    wait_cyc(a + L - 1);
    chk("t1_not_early", rv, 0);
    wait_cyc(a + L);
    chk("t1_valid", rv, 1);
    chk("t1_tag", rtag, 1);
    chk("t1_addr", raddr, 32'h1000);
    chk("t1_data", rdata, 64'h11223344_55667788);
    wait_cyc(a + L + 1);
    chk("t1_pulse_one", rv, 0);
    chk("t1_hold", rdata, 64'h11223344_55667788);

    req(1'b1, 1'b0, 32'h1003, MEM_SIZE_B, 32'h000000AB, a);
    req(1'b0, 1'b0, 32'h1000, 3'b000, 32'h0, b);
    chk("t2_accept_next", b - a, 1);
    wait_cyc(a + 2 * L);
    chk("t2_valid", rv, 1);
    chk("t2_tag", rtag, 0);
    chk("t2_data", rdata, 64'h11223344_AB667788);
    wait_cyc(last_comp + 2);

    req(1'b1, 1'b0, 32'h1002, MEM_SIZE_W, 32'hFFFFFFFF, a);
    req(1'b1, 1'b0, 32'h1000, 3'b011, 32'hFFFFFFFF, a);
    req(1'b0, 1'b0, 32'h1000, 3'b000, 32'h0, a);
    wait_cyc(last_comp);
    chk("t4_valid", rv, 1);
    chk("t4_data", rdata, 64'h11223344_AB667788);
    wait_cyc(last_comp + 2);

    for (int i = 0; i < 5; i++)
      req(1'b0, i[0], t3_a[i], 3'b000, 32'h0, acc[i]);
    chk("t3_accept_span", acc[4] - acc[0], 4);
    chk("t3_full", ready, 0);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(acc[0] + L * (i + 1));
      chk("t3_valid", rv, 1);
      chk("t3_tag", rtag, i[0]);
      chk("t3_addr", raddr, t3_ra[i]);
      chk("t3_data", rdata, t3_d[i]);
    end
    wait_cyc(last_comp + 2);

    req(1'b0, 1'b1, 32'h1000, 3'b000, 32'h0, a);
    tick(4);
    rst_aL = 1'b0;
    #1;
    chk("t5_rst_valid", rv, 0);
    chk("t5_rst_tag", rtag, 0);
    chk("t5_rst_addr", raddr, 0);
    chk("t5_rst_data", rdata, 0);
    chk("t5_rst_ready", ready, 0);
    do_reset(2);
    wait_cyc(a + L);
    chk("t5_dropped", rv, 0);
    req(1'b0, 1'b0, 32'h1000, 3'b000, 32'h0, b);
    wait_cyc(b + L);
    chk("t5_valid", rv, 1);
    chk("t5_data", rdata, 64'h11223344_AB667788);
    wait_cyc(last_comp + 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
